mipi_dphy_rx_byte_align: RTL and testbench

Receive-side counterpart of the D-PHY TX clock/serializer path. It sits after the lane ISERDES and its div-4 byte clock. It takes unaligned 8-bit words from one HS data lane, hunts for the HS sync byte at any of the 8 bit offsets, then locks that offset and emits byte-aligned payload to the CSI-2 packet layer. It also reports sync failures.

---
 rtl/mipi_dphy_rx_byte_align.sv | 164 ++++++++++++++++
 tb/tb_mipi_dphy_rx_byte_align.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_dphy_rx_byte_align.sv
// D-PHY HS receive byte aligner: hunts for the sync byte at any of 8 bit offsets
// in the deserialized stream, then emits byte-aligned payload at that offset.
module mipi_dphy_rx_byte_align #(
    parameter logic [7:0] SYNC_CODE       = 8'hB8,
    parameter int         TIMEOUT         = 32,
    parameter int         ERR_COUNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_hs_active,
    input  logic                       s_valid,
    input  logic [7:0]                 s_data,
    output logic                       m_valid,
    output logic                       m_first,
    output logic [7:0]                 m_data,
    output logic                       m_locked,
    output logic [2:0]                 m_offset,
    output logic                       err_sync,
    output logic [ERR_COUNT_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2,
        FAIL   = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] prev;
    logic [7:0] hunt_cnt;
    logic       first_pending;

    logic [15:0] window;
    logic        match_found;
    logic [2:0]  match_k;
    logic [7:0]  aligned;
    logic        timeout_hit;

    assign window  = {s_data, prev};
    assign aligned = window[m_offset +: 8];

    // Descending scan so the lowest matching offset wins.
    always_comb begin
        match_found = 1'b0;
        match_k     = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (window[k +: 8] == SYNC_CODE) begin
                match_found = 1'b1;
                match_k     = 3'(k);
            end
        end
    end

    assign timeout_hit = (state == HUNT) && s_hs_active && s_valid &&
                         !match_found && (hunt_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (s_hs_active) begin
                    next_state = HUNT;
                end
            end
            HUNT: begin
                if (!s_hs_active) begin
                    next_state = IDLE;
                end else if (s_valid && match_found) begin
                    next_state = LOCKED;
                end else if (timeout_hit) begin
                    next_state = FAIL;
                end
            end
            LOCKED: begin
                if (!s_hs_active) begin
                    next_state = IDLE;
                end
            end
            FAIL: begin
                if (!s_hs_active) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A byte arriving with s_hs_active low is dropped; only the already
    // registered output (if any) completes in that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev          <= 8'h00;
            hunt_cnt      <= 8'h00;
            first_pending <= 1'b0;
            m_valid       <= 1'b0;
            m_first       <= 1'b0;
            m_data        <= 8'h00;
            m_locked      <= 1'b0;
            m_offset      <= 3'd0;
            err_sync      <= 1'b0;
            err_count     <= '0;
        end else begin
            m_valid  <= 1'b0;
            m_first  <= 1'b0;
            err_sync <= 1'b0;
            case (state)
                IDLE: begin
                    prev     <= 8'h00;
                    hunt_cnt <= 8'h00;
                    m_locked <= 1'b0;
                end
                HUNT: begin
                    if (!s_hs_active) begin
                        m_locked <= 1'b0;
                    end else if (s_valid) begin
                        prev <= s_data;
                        if (match_found) begin
                            m_offset      <= match_k;
                            m_locked      <= 1'b1;
                            first_pending <= 1'b1;
                        end else if (timeout_hit) begin
                            err_sync <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + 1'b1;
                            end
                        end else begin
                            hunt_cnt <= hunt_cnt + 8'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (!s_hs_active) begin
                        m_locked <= 1'b0;
                    end else if (s_valid) begin
                        prev          <= s_data;
                        m_valid       <= 1'b1;
                        m_data        <= aligned;
                        m_first       <= first_pending;
                        first_pending <= 1'b0;
                    end
                end
                FAIL: begin
                    m_locked <= 1'b0;
                end
                default: begin
                    m_locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_dphy_rx_byte_align.sv
// Scoreboard bench for mipi_dphy_rx_byte_align: expected payload bytes are queued
// as stimulus is driven and checked against m_valid beats by a negedge monitor.
module tb_mipi_dphy_rx_byte_align;

    localparam int ECW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           s_hs_active;
    logic           s_valid;
    logic [7:0]     s_data;
    logic           m_valid;
    logic           m_first;
    logic [7:0]     m_data;
    logic           m_locked;
    logic [2:0]     m_offset;
    logic           err_sync;
    logic [ECW-1:0] err_count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       first;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mipi_dphy_rx_byte_align #(
        .SYNC_CODE      (8'hB8),
        .TIMEOUT        (32),
        .ERR_COUNT_WIDTH(ECW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_hs_active(s_hs_active),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_first    (m_first),
        .m_data     (m_data),
        .m_locked   (m_locked),
        .m_offset   (m_offset),
        .err_sync   (err_sync),
        .err_count  (err_count)
    );

    // Every output beat must match the oldest queued expectation.
    always @(negedge clk) begin
        if (m_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat got data=%h first=%b required no beat", m_data, m_first);
            end else begin
                mon_e = exp_q.pop_front();
                if ({m_first, m_data} !== {mon_e.first, mon_e.data}) begin
                    bad++;
                    $display("FAIL beat got data=%h first=%b required data=%h first=%b",
                             m_data, m_first, mon_e.data, mon_e.first);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive(input logic v, input logic [7:0] d);
        s_valid = v;
        s_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic f, input logic [7:0] d);
        exp_t e;
        e.first = f;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic start_burst();
        s_hs_active = 1'b1;
        drive(1'b0, 8'h00);
    endtask

    task automatic end_burst();
        s_hs_active = 1'b0;
        drive(1'b0, 8'h00);
    endtask

    // Sync B8 at bit offset 3: raw bytes 00 00 C0 95, lock after 95.
    task automatic hunt_offset3();
        start_burst();
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'hC0);
        drive(1'b1, 8'h95);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_hs_active = 1'b0;
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        total++;
        if ({m_valid, m_first, m_data, m_locked, m_offset, err_sync, err_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got %b required all zero",
                     {m_valid, m_first, m_data, m_locked, m_offset, err_sync, err_count});
        end
        reset = 1'b0;
        drive(1'b0, 8'h00);
    endtask

    task automatic test_offset3();
        hunt_offset3();
        total++;
        if ({m_locked, m_offset} !== {1'b1, 3'd3}) begin
            bad++;
            $display("FAIL off3_lock got locked=%b offset=%0d required locked=1 offset=3", m_locked, m_offset);
        end
        push(1'b1, 8'h12);
        drive(1'b1, 8'hA0);
        drive(1'b0, 8'h00);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL off3_drain got pending=%0d required 0", exp_q.size());
        end
        end_burst();
        total++;
        if ({m_locked, m_offset} !== {1'b0, 3'd3}) begin
            bad++;
            $display("FAIL off3_end got locked=%b offset=%0d required locked=0 offset=3", m_locked, m_offset);
        end
    endtask

    task automatic test_offset0();
        start_burst();
        drive(1'b1, 8'h00);
        drive(1'b1, 8'hB8);
        total++;
        if (m_locked !== 1'b0) begin
            bad++;
            $display("FAIL off0_early got locked=%b required 0", m_locked);
        end
        drive(1'b1, 8'h12);
        total++;
        if ({m_locked, m_offset} !== {1'b1, 3'd0}) begin
            bad++;
            $display("FAIL off0_lock got locked=%b offset=%0d required locked=1 offset=0", m_locked, m_offset);
        end
        push(1'b1, 8'h12);
        drive(1'b1, 8'h34);
        push(1'b0, 8'h34);
        drive(1'b1, 8'h56);
        drive(1'b0, 8'h00);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL off0_drain got pending=%0d required 0", exp_q.size());
        end
        end_burst();
    endtask

    task automatic test_timeout();
        start_burst();
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 8'h00);
        end
        total++;
        if (err_sync !== 1'b0) begin
            bad++;
            $display("FAIL to_early got err_sync=%b required 0", err_sync);
        end
        drive(1'b1, 8'h00);
        total++;
        if ({err_sync, err_count, m_locked} !== {1'b1, 2'd1, 1'b0}) begin
            bad++;
            $display("FAIL to_hit got err_sync=%b err_count=%0d locked=%b required 1 1 0",
                     err_sync, err_count, m_locked);
        end
        drive(1'b1, 8'hB8);
        total++;
        if ({err_sync, err_count} !== {1'b0, 2'd1}) begin
            bad++;
            $display("FAIL to_pulse got err_sync=%b err_count=%0d required 0 1", err_sync, err_count);
        end
        drive(1'b1, 8'h12);
        drive(1'b1, 8'h34);
        total++;
        if (m_locked !== 1'b0) begin
            bad++;
            $display("FAIL to_fail_hold got locked=%b required 0", m_locked);
        end
        end_burst();
        hunt_offset3();
        total++;
        if ({m_locked, m_offset} !== {1'b1, 3'd3}) begin
            bad++;
            $display("FAIL to_relock got locked=%b offset=%0d required locked=1 offset=3", m_locked, m_offset);
        end
        push(1'b1, 8'h12);
        drive(1'b1, 8'hA0);
        drive(1'b0, 8'h00);
        end_burst();
    endtask

    task automatic test_burst_end();
        hunt_offset3();
        push(1'b1, 8'h12);
        drive(1'b1, 8'hA0);
        s_hs_active = 1'b0;
        drive(1'b1, 8'h77);
        total++;
        if ({m_locked, m_valid} !== 2'b00) begin
            bad++;
            $display("FAIL end_drop got locked=%b valid=%b required 0 0", m_locked, m_valid);
        end
        // Sync at offset 5 followed by payload 5A C3.
        start_burst();
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h57);
        total++;
        if ({m_locked, m_offset} !== {1'b1, 3'd5}) begin
            bad++;
            $display("FAIL end_off5 got locked=%b offset=%0d required locked=1 offset=5", m_locked, m_offset);
        end
        push(1'b1, 8'h5A);
        drive(1'b1, 8'h6B);
        push(1'b0, 8'hC3);
        drive(1'b1, 8'h18);
        drive(1'b0, 8'h00);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL end_drain got pending=%0d required 0", exp_q.size());
        end
        end_burst();
    endtask

    task automatic test_gapped();
        logic [7:0] bytes [3];
        logic [7:0] outs  [3];
        bytes = '{8'hA0, 8'hB1, 8'h02};
        outs  = '{8'h12, 8'h34, 8'h56};
        hunt_offset3();
        for (int i = 0; i < 3; i++) begin
            push(i == 0, outs[i]);
            drive(1'b1, bytes[i]);
            total++;
            if (m_valid !== 1'b1) begin
                bad++;
                $display("FAIL gap_on%0d got valid=%b required 1", i, m_valid);
            end
            drive(1'b0, 8'hFF);
            total++;
            if (m_valid !== 1'b0) begin
                bad++;
                $display("FAIL gap_off%0d got valid=%b required 0", i, m_valid);
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL gap_drain got pending=%0d required 0", exp_q.size());
        end
        end_burst();
    endtask

    task automatic test_saturation_reset();
        int exp_cnt;
        for (int t = 0; t < 4; t++) begin
            start_burst();
            for (int i = 0; i < 32; i++) begin
                drive(1'b1, 8'h00);
            end
            exp_cnt = (t + 2 > 3) ? 3 : t + 2;
            total++;
            if (err_count !== ECW'(exp_cnt)) begin
                bad++;
                $display("FAIL sat%0d got err_count=%0d required %0d", t, err_count, exp_cnt);
            end
            end_burst();
        end
        hunt_offset3();
        push(1'b1, 8'h12);
        drive(1'b1, 8'hA0);
        reset = 1'b1;
        drive(1'b1, 8'hB1);
        total++;
        if ({m_valid, m_first, m_data, m_locked, m_offset, err_sync, err_count} !== '0) begin
            bad++;
            $display("FAIL mid_reset got %b required all zero",
                     {m_valid, m_first, m_data, m_locked, m_offset, err_sync, err_count});
        end
        reset = 1'b0;
        s_hs_active = 1'b0;
        drive(1'b0, 8'h00);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL reset_drain got pending=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        reset       = 1'b1;
        s_hs_active = 1'b0;
        s_valid     = 1'b0;
        s_data      = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_offset3();
        test_offset0();
        test_timeout();
        test_burst_end();
        test_gapped();
        test_saturation_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
